ascon_ctrl_fsm: RTL and testbench



---
 rtl/ascon_ctrl_fsm_if.sv | 48 ++++
 rtl/ascon_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm_if
// Control bus between an ASCON encryption control FSM and the party that
// requests encryptions and drives the datapath.
//   start_i          request a new encryption
//   data_valid_i     AD/plaintext block present on the datapath data bus
//   data_ready_o     FSM is waiting for the next data block
//   select_o         1 = permutation input from external initial state
//   enable_o         state-register load enable
//   xor_data_begin_o / xor_key_begin_o   pre-round XOR of data / key
//   xor_key_end_o / xor_ext_end_o        post-round XOR of key / domain bit
//   round_o          round constant index
//   cipher_valid_o   ciphertext word valid this cycle
//   tag_valid_o      tag valid in state register this cycle
//   done_o           encryption complete
// Signal suffixes are given from the FSM's point of view.
// ---------------------------------------------------------------------------
interface ascon_ctrl_fsm_if;
  logic       start_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic       select_o;
  logic       enable_o;
  logic       xor_data_begin_o;
  logic       xor_key_begin_o;
  logic       xor_key_end_o;
  logic       xor_ext_end_o;
  logic [3:0] round_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       done_o;

  // Requester / datapath side
  modport master (
    output start_i, data_valid_i,
    input  data_ready_o, select_o, enable_o, xor_data_begin_o,
           xor_key_begin_o, xor_key_end_o, xor_ext_end_o, round_o,
           cipher_valid_o, tag_valid_o, done_o
  );

  // Control FSM side
  modport slave (
    input  start_i, data_valid_i,
    output data_ready_o, select_o, enable_o, xor_data_begin_o,
           xor_key_begin_o, xor_key_end_o, xor_ext_end_o, round_o,
           cipher_valid_o, tag_valid_o, done_o
  );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm
// Sequencing FSM for an ASCON-128 style encryption: 12-round initialisation,
// one associated-data block (6 rounds), NB_PT-1 plaintext blocks (6 rounds
// each) and a final block with 12-round finalisation producing the tag.
// Ports:
//   clock_i  system clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      ascon_ctrl_fsm_if.slave (start/data handshake and datapath
//            control strobes, see the interface file)
// All outputs are Moore-decoded from the registered state, round counter
// rc and block counter bc.
// ---------------------------------------------------------------------------
module ascon_ctrl_fsm #(
  parameter int NB_PT = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  ascon_ctrl_fsm_if.slave       bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_WAIT_FIN,
    S_FIN,
    S_DONE
  } state_t;

  localparam logic [3:0] RC_LAST  = 4'd11;
  localparam logic [3:0] RC_HALF  = 4'd6;
  localparam logic [3:0] BC_FINAL = 4'(NB_PT - 1);

  state_t     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic [3:0] bc_q, bc_d;

  logic       data_ready, sel, en, xdb, xkb, xke, xee, cv, tag, done;
  logic [3:0] round;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rc_q    <= 4'd0;
      bc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      bc_q    <= bc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    bc_d       = bc_q;
    data_ready = 1'b0;
    sel        = 1'b0;
    en         = 1'b0;
    xdb        = 1'b0;
    xkb        = 1'b0;
    xke        = 1'b0;
    xee        = 1'b0;
    cv         = 1'b0;
    tag        = 1'b0;
    done       = 1'b0;
    round      = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_INIT;
          rc_d    = 4'd0;
          bc_d    = 4'd0;
        end
      end

      S_INIT: begin
        en    = 1'b1;
        round = rc_q;
        sel   = (rc_q == 4'd0);
        xke   = (rc_q == RC_LAST);
        if (rc_q == RC_LAST) begin
          state_d = S_WAIT_AD;
          rc_d    = 4'd0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end

      S_WAIT_AD: begin
        data_ready = 1'b1;
        if (bus.data_valid_i) begin
          state_d = S_AD;
          rc_d    = RC_HALF;
        end
      end

      S_AD: begin
        en    = 1'b1;
        round = rc_q;
        xdb   = (rc_q == RC_HALF);
        xee   = (rc_q == RC_LAST);
        if (rc_q == RC_LAST) begin
          state_d = S_WAIT_PT;
          rc_d    = 4'd0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end

      S_WAIT_PT: begin
        data_ready = 1'b1;
        if (bus.data_valid_i) begin
          state_d = S_PT;
          rc_d    = RC_HALF;
        end
      end

      S_PT: begin
        en    = 1'b1;
        round = rc_q;
        xdb   = (rc_q == RC_HALF);
        cv    = (rc_q == RC_HALF);
        if (rc_q == RC_LAST) begin
          // Last non-final plaintext block hands over to finalisation.
          bc_d    = bc_q + 4'd1;
          rc_d    = 4'd0;
          state_d = ((bc_q + 4'd1) == BC_FINAL) ? S_WAIT_FIN : S_WAIT_PT;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end

      S_WAIT_FIN: begin
        data_ready = 1'b1;
        if (bus.data_valid_i) begin
          state_d = S_FIN;
          rc_d    = 4'd0;
        end
      end

      S_FIN: begin
        en    = 1'b1;
        round = rc_q;
        xdb   = (rc_q == 4'd0);
        xkb   = (rc_q == 4'd0);
        cv    = (rc_q == 4'd0);
        xke   = (rc_q == RC_LAST);
        if (rc_q == RC_LAST) begin
          state_d = S_DONE;
          rc_d    = 4'd0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end

      S_DONE: begin
        done = 1'b1;
        // rc doubles as a first-cycle marker while parked in DONE.
        tag  = (rc_q == 4'd0);
        if (bus.start_i) begin
          state_d = S_INIT;
          rc_d    = 4'd0;
          bc_d    = 4'd0;
        end else begin
          rc_d = 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        rc_d    = 4'd0;
        bc_d    = 4'd0;
      end
    endcase
  end

  assign bus.data_ready_o     = data_ready;
  assign bus.select_o         = sel;
  assign bus.enable_o         = en;
  assign bus.xor_data_begin_o = xdb;
  assign bus.xor_key_begin_o  = xkb;
  assign bus.xor_key_end_o    = xke;
  assign bus.xor_ext_end_o    = xee;
  assign bus.round_o          = round;
  assign bus.cipher_valid_o   = cv;
  assign bus.tag_valid_o      = tag;
  assign bus.done_o           = done;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ascon_ctrl_fsm
// Randomised and directed stimulus for ascon_ctrl_fsm, compared every cycle
// against a schedule-based reference model: an encryption is a list of
// segments (round bursts and data waits) walked by a segment/position pair.
// ---------------------------------------------------------------------------
module tb_ascon_ctrl_fsm;

  localparam int NB_PT = 4;

  localparam int K_RND  = 0;
  localparam int K_WAIT = 1;
  localparam int K_DONE = 2;

  localparam int P_INIT = 0;
  localparam int P_AD   = 1;
  localparam int P_PT   = 2;
  localparam int P_FIN  = 3;
  localparam int P_NONE = 4;

  logic clk = 1'b0;
  logic rst;

  ascon_ctrl_fsm_if bus ();

  ascon_ctrl_fsm #(.NB_PT(NB_PT)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference schedule
  int seg_kind[$];
  int seg_ph[$];
  int seg_rc0[$];
  int seg_len[$];
  int m_seg;   // -1 = idle
  int m_pos;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void add_seg(input int k, input int ph, input int rc0,
                                  input int len);
    seg_kind.push_back(k);
    seg_ph.push_back(ph);
    seg_rc0.push_back(rc0);
    seg_len.push_back(len);
  endfunction

  function automatic void build_schedule();
    add_seg(K_RND, P_INIT, 0, 12);
    add_seg(K_WAIT, P_NONE, 0, 0);
    add_seg(K_RND, P_AD, 6, 6);
    for (int b = 0; b < NB_PT - 1; b++) begin
      add_seg(K_WAIT, P_NONE, 0, 0);
      add_seg(K_RND, P_PT, 6, 6);
    end
    add_seg(K_WAIT, P_NONE, 0, 0);
    add_seg(K_RND, P_FIN, 0, 12);
    add_seg(K_DONE, P_NONE, 0, 0);
  endfunction

  // {ready,select,enable,xdb,xkb,xke,xee,round[3:0],cv,tag,done}
  function automatic logic [13:0] model_out();
    logic rdy, sel, en, xdb, xkb, xke, xee, cv, tg, dn;
    logic [3:0] rnd;
    int rc;
    {rdy, sel, en, xdb, xkb, xke, xee, cv, tg, dn} = '0;
    rnd = 4'd0;
    if (m_seg >= 0) begin
      if (seg_kind[m_seg] == K_WAIT) begin
        rdy = 1'b1;
      end else if (seg_kind[m_seg] == K_DONE) begin
        dn = 1'b1;
        tg = (m_pos == 0);
      end else begin
        rc  = seg_rc0[m_seg] + m_pos;
        en  = 1'b1;
        rnd = 4'(rc);
        case (seg_ph[m_seg])
          P_INIT: begin sel = (rc == 0); xke = (rc == 11); end
          P_AD:   begin xdb = (rc == 6); xee = (rc == 11); end
          P_PT:   begin xdb = (rc == 6); cv = (rc == 6); end
          default: begin
            xdb = (rc == 0); xkb = (rc == 0); cv = (rc == 0);
            xke = (rc == 11);
          end
        endcase
      end
    end
    return {rdy, sel, en, xdb, xkb, xke, xee, rnd, cv, tg, dn};
  endfunction

  function automatic void model_advance(input logic st, input logic dv);
    if (m_seg < 0) begin
      if (st) begin m_seg = 0; m_pos = 0; end
    end else if (seg_kind[m_seg] == K_DONE) begin
      if (st) begin m_seg = 0; m_pos = 0; end
      else m_pos = 1;
    end else if (seg_kind[m_seg] == K_WAIT) begin
      if (dv) begin m_seg++; m_pos = 0; end
    end else begin
      m_pos++;
      if (m_pos == seg_len[m_seg]) begin m_seg++; m_pos = 0; end
    end
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.data_ready_o, bus.select_o, bus.enable_o,
            bus.xor_data_begin_o, bus.xor_key_begin_o, bus.xor_key_end_o,
            bus.xor_ext_end_o, bus.round_o, bus.cipher_valid_o,
            bus.tag_valid_o, bus.done_o};
  endfunction

  // Called on a falling edge: drive inputs, advance model over the next
  // rising edge, then compare on the following falling edge.
  task automatic step(input logic st, input logic dv);
    bus.start_i      = st;
    bus.data_valid_i = dv;
    model_advance(st, dv);
    @(posedge clk);
    @(negedge clk);
    check_eq("outputs", 32'(dut_vec()), 32'(model_out()));
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_outputs", 32'(dut_vec()), 32'd0);
    m_seg = -1;
    m_pos = 0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_release_outputs", 32'(dut_vec()), 32'd0);
  endtask

  function automatic bit model_at(input int ph, input int rc);
    if (m_seg < 0) return 1'b0;
    if (seg_kind[m_seg] != K_RND) return 1'b0;
    return (seg_ph[m_seg] == ph) && (seg_rc0[m_seg] + m_pos == rc);
  endfunction

  function automatic bit model_in_wait_pt();
    if (m_seg <= 0) return 1'b0;
    return seg_kind[m_seg] == K_WAIT && seg_ph[m_seg + 1] == P_PT;
  endfunction

  initial begin
    int cyc, n_cv, n_xee, guard;
    build_schedule();
    m_seg = -1;
    m_pos = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.data_valid_i = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("idle_outputs", 32'(dut_vec()), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Full run with data_valid held high: latency and pulse counts.
    step(1'b1, 1'b1);
    check_eq("init_select_first", 32'(bus.select_o), 32'd1);
    cyc = 1;
    n_cv = 0;
    n_xee = 0;
    while (!bus.tag_valid_o && cyc < 100) begin
      n_cv  += int'(bus.cipher_valid_o);
      n_xee += int'(bus.xor_ext_end_o);
      // start pulses during AD and FIN must be ignored
      step(model_at(P_AD, 8) || model_at(P_FIN, 3), 1'b1);
      cyc++;
    end
    check_eq("tag_latency", 32'(cyc), 32'd54);
    check_eq("cipher_pulses", 32'(n_cv), 32'(NB_PT));
    check_eq("ext_end_pulses", 32'(n_xee), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check_eq("done_held", 32'(bus.done_o), 32'd1);
    check_eq("tag_one_cycle", 32'(bus.tag_valid_o), 32'd0);

    // Restart from DONE, stall 5 cycles in WAIT_PT, then reset at PT rc=8.
    step(1'b1, 1'b1);
    check_eq("restart_done_low", 32'(bus.done_o), 32'd0);
    guard = 0;
    while (!model_in_wait_pt() && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check_eq("reach_wait_pt", 32'(guard < 200), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_eq("stall_enable", 32'(bus.enable_o), 32'd0);
      check_eq("stall_ready", 32'(bus.data_ready_o), 32'd1);
    end
    step(1'b0, 1'b1);
    check_eq("resume_rc6", 32'(bus.round_o), 32'd6);
    guard = 0;
    while (!model_at(P_PT, 8) && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check_eq("reach_pt_rc8", 32'(bus.round_o), 32'd8);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check_eq("reinit_select", 32'(bus.select_o), 32'd1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
